calc_display_seq: RTL and testbench

Parametrised successor to the four-bit calculator display. It latches two WIDTH-bit unsigned operands and an opcode on a start strobe, and computes add, subtract, multiply or divide. The magnitude is converted to BCD by a sequential (one shift per clock) double-dabble engine. The result is multiplexed onto a DIGITS-digit common-anode seven-segment display with leading-zero blanking and a floating minus sign. It sits between the board switch/button logic and the display pins.

---
 rtl/calc_display_seq_if.sv | 25 ++
 rtl/calc_display_seq.sv | 213 +++++++++++++++++++++
 tb/tb_calc_display_seq.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/calc_display_seq_if.sv
// Operand/result bundle between the board switch logic and calc_display_seq.
interface calc_display_seq_if #(
    parameter int WIDTH  = 4,
    parameter int DIGITS = 8
) ();
    logic              start;
    logic [1:0]        OP;
    logic [WIDTH-1:0]  A;
    logic [WIDTH-1:0]  B;
    logic              busy;
    logic              done;
    logic [1:0]        overflow_cout;
    logic [DIGITS-1:0] led_enable;
    logic [6:0]        seven_seg;

    modport master (
        output start, OP, A, B,
        input  busy, done, overflow_cout, led_enable, seven_seg
    );

    modport slave (
        input  start, OP, A, B,
        output busy, done, overflow_cout, led_enable, seven_seg
    );
endinterface

// File: rtl/calc_display_seq.sv
// Four-function calculator with sequential double-dabble BCD conversion and
// a multiplexed common-anode seven-segment display.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for start; operands latched on start
// CALC   | compute magnitude, sign, carry/borrow, divide error
// SHIFT  | one double-dabble shift per clock, 2*WIDTH clocks
// COMMIT | copy BCD/flags into display registers, pulse done
module calc_display_seq #(
    parameter int WIDTH       = 4,
    parameter int DIGITS      = 8,
    parameter int REFRESH_DIV = 100000
) (
    input  logic clk,
    input  logic rst,
    calc_display_seq_if.slave bus
);
    localparam int M  = 2 * WIDTH;
    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(M);
    localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_MINUS = 7'h3F;
    localparam logic [6:0] SEG_E     = 7'h06;

    typedef enum logic [1:0] {IDLE, CALC, SHIFT, COMMIT} state_t;

    state_t           state;
    logic [1:0]       op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [M-1:0]     bin;
    logic [BW-1:0]    bcd;
    logic [BW-1:0]    bcd_adj;
    logic [CW-1:0]    cnt;
    logic             neg_w;
    logic             err_w;
    logic             cb_w;
    logic             busy_q;
    logic             done_q;
    logic [1:0]       ovf_q;

    logic [BW-1:0]    disp_bcd;
    logic             disp_neg;
    logic             disp_err;

    logic [PW-1:0]     presc;
    logic [IW-1:0]     scan_idx;
    logic [DIGITS-1:0] led_q;
    logic [6:0]        seg_q;
    logic [6:0]        seg_next;
    logic [3:0]        cur_nib;
    int                msd;

    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] diff;
    logic [M-1:0]     prod;
    logic [WIDTH-1:0] quot;

    assign sum  = {1'b0, a_q} + {1'b0, b_q};
    assign diff = (a_q >= b_q) ? (a_q - b_q) : (b_q - a_q);
    assign prod = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};
    assign quot = (b_q == '0) ? '0 : (a_q / b_q);

    function automatic logic [6:0] seg_digit(input logic [3:0] d);
        case (d)
            4'd0:    seg_digit = 7'h40;
            4'd1:    seg_digit = 7'h79;
            4'd2:    seg_digit = 7'h24;
            4'd3:    seg_digit = 7'h30;
            4'd4:    seg_digit = 7'h19;
            4'd5:    seg_digit = 7'h12;
            4'd6:    seg_digit = 7'h02;
            4'd7:    seg_digit = 7'h78;
            4'd8:    seg_digit = 7'h00;
            4'd9:    seg_digit = 7'h10;
            default: seg_digit = SEG_BLANK;
        endcase
    endfunction

    // Add-3 correction of every BCD nibble ahead of the next shift.
    always_comb begin
        bcd_adj = bcd;
        for (int d = 0; d < DIGITS; d++) begin
            if (bcd[4*d +: 4] >= 4'd5)
                bcd_adj[4*d +: 4] = bcd[4*d +: 4] + 4'd3;
        end
    end

    // Conversion sequencer; display registers only change in COMMIT.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            bin      <= '0;
            bcd      <= '0;
            cnt      <= '0;
            neg_w    <= 1'b0;
            err_w    <= 1'b0;
            cb_w     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            ovf_q    <= '0;
            disp_bcd <= '0;
            disp_neg <= 1'b0;
            disp_err <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        op_q   <= bus.OP;
                        a_q    <= bus.A;
                        b_q    <= bus.B;
                        busy_q <= 1'b1;
                        state  <= CALC;
                    end
                end
                CALC: begin
                    bcd   <= '0;
                    cnt   <= '0;
                    neg_w <= 1'b0;
                    err_w <= 1'b0;
                    cb_w  <= 1'b0;
                    case (op_q)
                        2'b00: begin
                            bin  <= {{(WIDTH-1){1'b0}}, sum};
                            cb_w <= sum[WIDTH];
                        end
                        2'b01: begin
                            bin   <= {{WIDTH{1'b0}}, diff};
                            neg_w <= (a_q < b_q);
                            cb_w  <= (a_q < b_q);
                        end
                        2'b10: bin <= prod;
                        default: begin
                            bin   <= {{WIDTH{1'b0}}, quot};
                            err_w <= (b_q == '0);
                        end
                    endcase
                    state <= SHIFT;
                end
                SHIFT: begin
                    {bcd, bin} <= {bcd_adj, bin} << 1;
                    cnt        <= cnt + 1'b1;
                    if (cnt == CW'(M - 1))
                        state <= COMMIT;
                end
                default: begin
                    disp_bcd <= bcd;
                    disp_neg <= neg_w && (bcd != '0);
                    disp_err <= err_w;
                    ovf_q    <= {err_w, cb_w};
                    done_q   <= 1'b1;
                    busy_q   <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

    // Content of the digit currently selected by the scan.
    always_comb begin
        msd = 0;
        for (int d = 0; d < DIGITS; d++) begin
            if (disp_bcd[4*d +: 4] != 4'd0)
                msd = d;
        end
        cur_nib  = disp_bcd[4*scan_idx +: 4];
        seg_next = SEG_BLANK;
        if (disp_err) begin
            if (scan_idx == '0)
                seg_next = SEG_E;
        end else if (int'(scan_idx) <= msd) begin
            seg_next = seg_digit(cur_nib);
        end else if (disp_neg && (int'(scan_idx) == msd + 1)) begin
            seg_next = SEG_MINUS;
        end
    end

    // Free-running digit scan with registered enable/segment outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            presc    <= '0;
            scan_idx <= '0;
            led_q    <= '1;
            seg_q    <= SEG_BLANK;
        end else begin
            if (presc == PW'(REFRESH_DIV - 1)) begin
                presc <= '0;
                if (scan_idx == IW'(DIGITS - 1))
                    scan_idx <= '0;
                else
                    scan_idx <= scan_idx + 1'b1;
            end else begin
                presc <= presc + 1'b1;
            end
            led_q <= ~(DIGITS'(1) << scan_idx);
            seg_q <= seg_next;
        end
    end

    assign bus.busy          = busy_q;
    assign bus.done          = done_q;
    assign bus.overflow_cout = ovf_q;
    assign bus.led_enable    = led_q;
    assign bus.seven_seg     = seg_q;
endmodule

// File: tb/tb_calc_display_seq.sv
// Directed bench for calc_display_seq (WIDTH=4, DIGITS=8, REFRESH_DIV=2).
module tb_calc_display_seq;
    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    calc_display_seq_if #(.WIDTH(4), .DIGITS(8)) bus ();

    calc_display_seq #(.WIDTH(4), .DIGITS(8), .REFRESH_DIV(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    localparam logic [6:0] BL = 7'h7F;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0][6:0] mk(input logic [6:0] d2, input logic [6:0] d1, input logic [6:0] d0);
        mk = {BL, BL, BL, BL, BL, d2, d1, d0};
    endfunction

    // Watch one full scan sweep and compare every digit.
    task automatic sweep(input string tag, input logic [7:0][6:0] exp);
        logic [7:0][6:0] got;
        logic [7:0]      seen;
        int              bad;
        got  = '1;
        seen = '0;
        bad  = 0;
        for (int c = 0; c < 18; c++) begin
            @(negedge clk);
            if ($countones(~bus.led_enable) != 1) begin
                bad++;
            end else begin
                for (int i = 0; i < 8; i++)
                    if (!bus.led_enable[i]) begin
                        got[i]  = bus.seven_seg;
                        seen[i] = 1'b1;
                    end
            end
        end
        check({tag, "_onehot"}, bad, 0);
        check({tag, "_seen"}, seen, 8'hFF);
        for (int i = 0; i < 8; i++)
            check($sformatf("%s_d%0d", tag, i), got[i], exp[i]);
    endtask

    // One conversion; optionally pulse start (with other operands) while busy.
    task automatic conv(input string tag, input logic [1:0] op, input logic [3:0] a, input logic [3:0] b,
                        input bit pulse, input logic [1:0] exp_ovf);
        int         nbusy;
        int         ndone;
        logic [1:0] ovf;
        nbusy = 0;
        ndone = 0;
        ovf   = 2'bxx;
        @(negedge clk);
        bus.start = 1'b1; bus.OP = op; bus.A = a; bus.B = b;
        @(negedge clk);
        bus.start = 1'b0;
        for (int c = 0; c < 30; c++) begin
            if (pulse && c == 3) begin
                bus.start = 1'b1; bus.A = 4'd15; bus.B = 4'd15; bus.OP = 2'b10;
            end else begin
                bus.start = 1'b0;
            end
            if (bus.busy) nbusy++;
            if (bus.done) begin
                ndone++;
                ovf = bus.overflow_cout;
            end
            @(negedge clk);
        end
        bus.start = 1'b0;
        check({tag, "_busy_cycles"}, nbusy, 10);
        check({tag, "_done_count"}, ndone, 1);
        check({tag, "_ovf"}, ovf, exp_ovf);
    endtask

    initial begin
        int ndone;
        rst = 1'b1;
        bus.start = 1'b0; bus.OP = 2'b00; bus.A = 4'd0; bus.B = 4'd0;

        @(negedge clk);
        check("rst_led", bus.led_enable, 8'hFF);
        check("rst_seg", bus.seven_seg, 7'h7F);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_done", bus.done, 1'b0);
        check("rst_ovf", bus.overflow_cout, 2'b00);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_led", bus.led_enable, 8'hFE);
        check("post_rst_seg", bus.seven_seg, 7'h40);
        sweep("zero", mk(BL, BL, 7'h40));

        conv("add_9_7", 2'b00, 4'd9, 4'd7, 1'b0, 2'b01);
        sweep("add_9_7", mk(BL, 7'h79, 7'h02));

        conv("sub_3_8", 2'b01, 4'd3, 4'd8, 1'b0, 2'b01);
        sweep("sub_3_8", mk(BL, 7'h3F, 7'h12));

        conv("sub_8_8", 2'b01, 4'd8, 4'd8, 1'b0, 2'b00);
        sweep("sub_8_8", mk(BL, BL, 7'h40));

        conv("mul_15_15", 2'b10, 4'd15, 4'd15, 1'b0, 2'b00);
        sweep("mul_15_15", mk(7'h24, 7'h24, 7'h12));

        conv("div_7_0", 2'b11, 4'd7, 4'd0, 1'b0, 2'b10);
        sweep("div_7_0", mk(BL, BL, 7'h06));

        conv("div_14_4", 2'b11, 4'd14, 4'd4, 1'b0, 2'b00);
        sweep("div_14_4", mk(BL, BL, 7'h30));

        conv("busy_start", 2'b00, 4'd2, 4'd3, 1'b1, 2'b00);
        sweep("busy_start", mk(BL, BL, 7'h12));

        // Abort 9*9 with reset in the fourth SHIFT cycle.
        @(negedge clk);
        bus.start = 1'b1; bus.OP = 2'b10; bus.A = 4'd9; bus.B = 4'd9;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        check("abort_busy_before", bus.busy, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", bus.busy, 1'b0);
        check("abort_led", bus.led_enable, 8'hFF);
        ndone = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (bus.done) ndone++;
        end
        check("abort_done", ndone, 0);
        check("abort_ovf", bus.overflow_cout, 2'b00);
        sweep("abort", mk(BL, BL, 7'h40));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
